// File: rtl/intarb.sv
// ----------------------------------------------------------------------------
// intarb -- Unibus BR/BG interrupt arbiter with vector capture.
//
// Watches the four bus-request lines BR7..BR4. When the CPU is at an
// instruction boundary and the bus is idle, it grants the highest pending
// level above the processor priority. It then follows the requester through
// SACK, BBSY+INTR and a short deskew before latching the interrupt vector
// from D7..D0. Finally it answers with SSYN until INTR is released.
//
// Ports
//   CLOCK          system clock, rising edge
//   RESET          synchronous active-low reset
//   cpu_pri[2:0]   processor priority level (0-7), sampled only in IDLE
//   cpu_ready      CPU may take an interrupt, sampled only in IDLE
//   br_in_h[3:0]   bus requests (bit 3 = BR7 ... bit 0 = BR4)
//   bbsy_in_h, sack_in_h, intr_in_h, syn_msyn_in_h, syn_ssyn_in_h
//                  Unibus control lines, active-high
//   init_in_h      Unibus INIT, same effect as RESET
//   d70_in_h[7:0]  Unibus data bits 7:0
//   bg_out_l[3:0]  bus grants BG7..BG4, active-low
//   ssyn_out_h     slave sync returned for the vector transfer
//   intvec_out     last captured vector (bits 1:0 forced to 0)
//   intlev_out     level (4-7) of the last captured vector
//   intvec_valid   one-clock strobe, intvec_out/intlev_out just updated
//   arb_err        one-clock strobe, grant/SACK timeout or INTR lost in deskew
//   state_dbg      current FSM state (IDLE=0 GRANT=1 SACKED=2 DESKEW=3 SSYN=4)
//
// Handshake: intvec_valid is a valid-only strobe with no ready; a consumer
// samples intvec_out/intlev_out in the cycle intvec_valid is high. The
// outputs themselves hold until the next capture.
// ----------------------------------------------------------------------------
module intarb (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [2:0] cpu_pri,
    input  logic       cpu_ready,
    input  logic [3:0] br_in_h,
    input  logic       bbsy_in_h,
    input  logic       sack_in_h,
    input  logic       intr_in_h,
    input  logic       syn_msyn_in_h,
    input  logic       syn_ssyn_in_h,
    input  logic       init_in_h,
    input  logic [7:0] d70_in_h,
    output logic [3:0] bg_out_l,
    output logic       ssyn_out_h,
    output logic [7:0] intvec_out,
    output logic [2:0] intlev_out,
    output logic       intvec_valid,
    output logic       arb_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SACKED = 3'd2,
        ST_DESKEW = 3'd3,
        ST_SSYN   = 3'd4
    } state_t;

    // A timer value of 254 at a clock edge means this edge takes it to 255.
    localparam logic [7:0] TMR_LAST  = 8'd254;
    // Deskew counter value on the third DESKEW clock.
    localparam logic [1:0] DSK_LAST  = 2'd2;

    state_t     state, state_nx;
    logic [7:0] tmr, tmr_nx;
    logic [1:0] dsk, dsk_nx;
    logic [1:0] lvl, lvl_nx;        // granted level minus 4
    logic [3:0] bg_nx;
    logic       ssyn_nx;
    logic [7:0] vec_nx;
    logic [2:0] lev_nx;
    logic       valid_nx;
    logic       err_nx;

    logic       bus_idle;
    logic [3:0] eligible;
    logic       any_eligible;
    logic [1:0] top_lvl;

    assign bus_idle = ~bbsy_in_h & ~sack_in_h & ~syn_msyn_in_h &
                      ~syn_ssyn_in_h & ~intr_in_h;

    // Request at level i+4 is eligible only above the processor priority.
    assign eligible = br_in_h & {cpu_pri < 3'd7, cpu_pri < 3'd6,
                                 cpu_pri < 3'd5, cpu_pri < 3'd4};
    assign any_eligible = |eligible;

    always_comb begin
        top_lvl = 2'd0;
        if (eligible[3])      top_lvl = 2'd3;
        else if (eligible[2]) top_lvl = 2'd2;
        else if (eligible[1]) top_lvl = 2'd1;
        else                  top_lvl = 2'd0;
    end

    assign state_dbg = state;

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        dsk_nx   = dsk;
        lvl_nx   = lvl;
        bg_nx    = 4'b1111;
        ssyn_nx  = 1'b0;
        vec_nx   = intvec_out;
        lev_nx   = intlev_out;
        valid_nx = 1'b0;
        err_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_ready && bus_idle && any_eligible) begin
                    state_nx = ST_GRANT;
                    lvl_nx   = top_lvl;
                    tmr_nx   = 8'd0;
                    bg_nx    = ~(4'b0001 << top_lvl);
                end
            end

            ST_GRANT: begin
                // The grant is fixed at lvl; new, higher requests are ignored.
                tmr_nx = tmr + 8'd1;
                if (sack_in_h) begin
                    state_nx = ST_SACKED;
                    tmr_nx   = 8'd0;
                end else if (!br_in_h[lvl]) begin
                    state_nx = ST_IDLE;
                end else if (tmr == TMR_LAST) begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                end else begin
                    bg_nx    = ~(4'b0001 << lvl);
                end
            end

            ST_SACKED: begin
                tmr_nx = tmr + 8'd1;
                if (intr_in_h && bbsy_in_h) begin
                    state_nx = ST_DESKEW;
                    dsk_nx   = 2'd0;
                end else if (!sack_in_h && !bbsy_in_h && !intr_in_h) begin
                    state_nx = ST_IDLE;
                end else if (tmr == TMR_LAST) begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                end
            end

            ST_DESKEW: begin
                if (!intr_in_h) begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                end else if (dsk == DSK_LAST) begin
                    state_nx = ST_SSYN;
                    vec_nx   = {d70_in_h[7:2], 2'b00};
                    lev_nx   = {1'b1, lvl};
                    ssyn_nx  = 1'b1;
                    valid_nx = 1'b1;
                end else begin
                    dsk_nx   = dsk + 2'd1;
                end
            end

            ST_SSYN: begin
                if (!intr_in_h) begin
                    state_nx = ST_IDLE;
                end else begin
                    ssyn_nx  = 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; INIT acts exactly like RESET.
    always_ff @(posedge CLOCK) begin
        if (!RESET || init_in_h) begin
            state        <= ST_IDLE;
            tmr          <= 8'd0;
            dsk          <= 2'd0;
            lvl          <= 2'd0;
            bg_out_l     <= 4'b1111;
            ssyn_out_h   <= 1'b0;
            intvec_out   <= 8'd0;
            intlev_out   <= 3'd0;
            intvec_valid <= 1'b0;
            arb_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            tmr          <= tmr_nx;
            dsk          <= dsk_nx;
            lvl          <= lvl_nx;
            bg_out_l     <= bg_nx;
            ssyn_out_h   <= ssyn_nx;
            intvec_out   <= vec_nx;
            intlev_out   <= lev_nx;
            intvec_valid <= valid_nx;
            arb_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_intarb.sv
// ----------------------------------------------------------------------------
// tb_intarb -- directed bench for intarb. Expected vector captures and error
// strobes are queued when the stimulus that causes them is issued; a monitor
// pops and compares whenever the DUT raises intvec_valid or arb_err. Grant
// lines, SSYN and the FSM state are checked inline.
// ----------------------------------------------------------------------------
module tb_intarb;

    logic       CLOCK;
    logic       RESET;
    logic [2:0] cpu_pri;
    logic       cpu_ready;
    logic [3:0] br_in_h;
    logic       bbsy_in_h, sack_in_h, intr_in_h;
    logic       syn_msyn_in_h, syn_ssyn_in_h, init_in_h;
    logic [7:0] d70_in_h;
    logic [3:0] bg_out_l;
    logic       ssyn_out_h;
    logic [7:0] intvec_out;
    logic [2:0] intlev_out;
    logic       intvec_valid;
    logic       arb_err;
    logic [2:0] state_dbg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SSYN = 3'd4;

    // Event word: {err, valid, vector[7:0], level[2:0]}
    logic [12:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    intarb dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .cpu_pri       (cpu_pri),
        .cpu_ready     (cpu_ready),
        .br_in_h       (br_in_h),
        .bbsy_in_h     (bbsy_in_h),
        .sack_in_h     (sack_in_h),
        .intr_in_h     (intr_in_h),
        .syn_msyn_in_h (syn_msyn_in_h),
        .syn_ssyn_in_h (syn_ssyn_in_h),
        .init_in_h     (init_in_h),
        .d70_in_h      (d70_in_h),
        .bg_out_l      (bg_out_l),
        .ssyn_out_h    (ssyn_out_h),
        .intvec_out    (intvec_out),
        .intlev_out    (intlev_out),
        .intvec_valid  (intvec_valid),
        .arb_err       (arb_err),
        .state_dbg     (state_dbg)
    );

    // Clock / reset
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bg"},    bg_out_l,     4'b1111);
        check({tag, " ssyn"},  ssyn_out_h,   1'b0);
        check({tag, " vec"},   intvec_out,   8'h00);
        check({tag, " lev"},   intlev_out,   3'd0);
        check({tag, " valid"}, intvec_valid, 1'b0);
        check({tag, " err"},   arb_err,      1'b0);
        check({tag, " state"}, state_dbg,    S_IDLE);
    endtask

    task automatic bus_quiet();
        bbsy_in_h = 0; sack_in_h = 0; intr_in_h = 0;
        syn_msyn_in_h = 0; syn_ssyn_in_h = 0;
    endtask

    // Drives SACK then BBSY+INTR with a vector, stopping once SSYN comes up.
    task automatic vector_cycle(input logic [7:0] d, input logic [2:0] lev, input string tag);
        sack_in_h = 1; br_in_h = 4'b0000;
        tick();
        check({tag, " bg after sack"}, bg_out_l, 4'b1111);
        sack_in_h = 0; bbsy_in_h = 1; intr_in_h = 1; d70_in_h = d;
        exp_q.push_back({1'b0, 1'b1, d[7:2], 2'b00, lev});
        tick(); tick(); tick();
        check({tag, " ssyn before capture"}, ssyn_out_h, 1'b0);
        tick();
        check({tag, " ssyn"}, ssyn_out_h, 1'b1);
        check({tag, " vec"},  intvec_out, {d[7:2], 2'b00});
        check({tag, " lev"},  intlev_out, lev);
    endtask

    // Monitor / scoreboard
    always @(negedge CLOCK) begin
        if (intvec_valid === 1'b1 || arb_err === 1'b1) begin
            logic [12:0] act;
            act = {arb_err, intvec_valid, intvec_out, intlev_out};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected event: got %0h expected none", act);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    tests_failed++;
                    $display("FAIL event: got %0h expected %0h", act, e);
                end
            end
        end
    end

    initial begin
        int n;
        RESET = 0; init_in_h = 0; cpu_pri = 0; cpu_ready = 1;
        br_in_h = 0; d70_in_h = 0;
        bus_quiet();
        tick(); tick();
        check_reset_outputs("reset");
        RESET = 1;
        tick();

        // Basic BR4 interrupt with vector 064 octal
        cpu_pri = 3; br_in_h = 4'b0001;
        tick();
        check("br4 grant", bg_out_l, 4'b1110);
        vector_cycle(8'o064, 3'd4, "br4");
        tick();
        check("br4 valid one pulse", intvec_valid, 1'b0);
        check("br4 ssyn held", ssyn_out_h, 1'b1);
        intr_in_h = 0; bbsy_in_h = 0;
        tick();
        check("br4 ssyn released", ssyn_out_h, 1'b0);
        check("br4 idle", state_dbg, S_IDLE);
        check("br4 vec held", intvec_out, 8'h34);

        // Priority selection and masking
        cpu_pri = 5; br_in_h = 4'b1010;
        tick();
        check("br7/br5 pri5", bg_out_l, 4'b0111);
        br_in_h = 4'b0000;
        tick();
        check("br7 release", bg_out_l, 4'b1111);
        check("br7 release err", arb_err, 1'b0);
        cpu_pri = 7; br_in_h = 4'b1010;
        tick(); tick();
        check("pri7 no grant", bg_out_l, 4'b1111);

        // Grant is not moved to a newly raised higher request
        cpu_pri = 3; br_in_h = 4'b0010;
        tick();
        check("br5 grant", bg_out_l, 4'b1101);
        br_in_h = 4'b1010; cpu_pri = 7;
        tick();
        check("br5 kept under br7 and pri change", bg_out_l, 4'b1101);
        cpu_pri = 3; br_in_h = 4'b1000;
        tick();
        check("br5 dropped", bg_out_l, 4'b1111);
        tick();
        check("br7 follows", bg_out_l, 4'b0111);
        br_in_h = 4'b0000;
        tick();

        // BR6 grant timeout
        cpu_pri = 0; br_in_h = 4'b0100;
        tick();
        check("br6 grant", bg_out_l, 4'b1011);
        exp_q.push_back({1'b1, 1'b0, 8'h34, 3'd4});
        n = 1;
        while (bg_out_l == 4'b1011 && n < 400) begin
            tick();
            if (bg_out_l == 4'b1011) n++;
        end
        check("br6 grant length", n, 255);
        check("br6 timeout bg", bg_out_l, 4'b1111);
        br_in_h = 4'b0000;
        tick();
        check("br6 err one pulse", arb_err, 1'b0);

        // Passive release and SACK withdrawal
        br_in_h = 4'b0010;
        tick();
        check("br5 grant 2", bg_out_l, 4'b1101);
        br_in_h = 4'b0000;
        tick();
        check("br5 passive bg", bg_out_l, 4'b1111);
        check("br5 passive err", arb_err, 1'b0);
        br_in_h = 4'b0010;
        tick();
        sack_in_h = 1;
        tick();
        check("br5 sacked bg", bg_out_l, 4'b1111);
        sack_in_h = 0; br_in_h = 4'b0000;
        tick();
        check("withdraw idle", state_dbg, S_IDLE);
        check("withdraw no valid", intvec_valid, 1'b0);

        // INTR lost during deskew
        br_in_h = 4'b1000;
        tick();
        sack_in_h = 1; br_in_h = 0;
        tick();
        sack_in_h = 0; bbsy_in_h = 1; intr_in_h = 1;
        tick();
        intr_in_h = 0;
        exp_q.push_back({1'b1, 1'b0, 8'h34, 3'd4});
        tick();
        check("deskew abort idle", state_dbg, S_IDLE);
        check("deskew abort ssyn", ssyn_out_h, 1'b0);
        bus_quiet();
        tick();

        // INIT during SSYN
        br_in_h = 4'b0001;
        tick();
        vector_cycle(8'hff, 3'd4, "init");
        check("init in ssyn", state_dbg, S_SSYN);
        init_in_h = 1;
        tick();
        check_reset_outputs("init");
        init_in_h = 0; bus_quiet();
        tick();

        // RESET during GRANT
        br_in_h = 4'b1000;
        tick();
        check("reset grant", bg_out_l, 4'b0111);
        RESET = 0;
        tick();
        check_reset_outputs("reset mid grant");
        RESET = 1; br_in_h = 0;
        tick();

        // Busy bus holds off the grant
        br_in_h = 4'b1000; syn_msyn_in_h = 1;
        tick(); tick();
        check("busy no grant", bg_out_l, 4'b1111);
        syn_msyn_in_h = 0;
        tick();
        check("idle grant", bg_out_l, 4'b0111);
        br_in_h = 0;
        tick(); tick();

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
